// File: rtl/hct138_rr_arbiter_pkg.sv
// Shared state encodings, decoder enable patterns and index helpers for hct138_rr_arbiter.
package hct138_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 8;

  typedef logic [2:0] idx_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Decoder enable triples packed as {G, G_2A, G_2B}.
  localparam logic [2:0] DEC_ENA = 3'b100;
  localparam logic [2:0] DEC_DIS = 3'b011;

  function automatic idx_t idx_add(idx_t a, idx_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/hct138_rr_arbiter_pick8.sv
// rr_pick8: combinational rotating-priority picker; search starts at ptr+1 and wraps mod 8.
module rr_pick8
  import hct138_rr_arbiter_pkg::*;
(
  input  logic [7:0] req,
  input  idx_t       ptr,
  output logic       any,
  output idx_t       idx
);

  idx_t w_pos;
  logic w_found;

  always_comb begin
    idx     = '0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // k+1 wraps to 0 on the last pass, so ptr itself is checked last.
      w_pos = idx_add(ptr, idx_t'(k + 1));
      if (!w_found && req[w_pos]) begin
        idx     = w_pos;
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/hct138_rr_arbiter.sv
// Round-robin arbiter sharing one HCT138 3-to-8 decoder among 8 requesters.
// Optional forced release after HOLD_MAX grant cycles is enabled by defining ARB_TIMEOUT_EN.
module hct138_rr_arbiter
  import hct138_rr_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned HOLD_MAX   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       G,
  output logic       G_2A,
  output logic       G_2B,
  output logic       busy,
  output logic       timeout
);

  logic [1:0] r_state;
  idx_t       r_sel;
  idx_t       r_ptr;
  logic [2:0] r_dec;
  logic [3:0] r_gap_cnt;
  logic       r_timeout;

  logic [1:0] w_state_d;
  idx_t       w_sel_d;
  idx_t       w_ptr_d;
  logic [2:0] w_dec_d;
  logic [3:0] w_gap_d;
  logic       w_any;
  idx_t       w_idx;
  logic       w_force;

  rr_pick8 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;

  // Value equals the number of completed GRANT cycles of the current grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_GRANT) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign w_force = (r_state == ST_GRANT) && req[r_sel] && (r_hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    w_dec_d   = r_dec;
    w_gap_d   = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_sel_d   = w_idx;
          w_dec_d   = DEC_ENA;
          w_state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // sel stays frozen here; only the owner's request line matters.
        if (!req[r_sel] || w_force) begin
          w_dec_d   = DEC_DIS;
          w_ptr_d   = r_sel;
          w_gap_d   = 4'(GAP_CYCLES - 1);
          w_state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_d = ST_IDLE;
        end else begin
          w_gap_d = r_gap_cnt - 4'd1;
        end
      end
      default: begin
        w_dec_d   = DEC_DIS;
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_ptr     <= '1;
      r_dec     <= DEC_DIS;
      r_gap_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_sel     <= w_sel_d;
      r_ptr     <= w_ptr_d;
      r_dec     <= w_dec_d;
      r_gap_cnt <= w_gap_d;
      r_timeout <= w_force;
    end
  end

  assign {C, B, A}       = r_sel;
  assign {G, G_2A, G_2B} = r_dec;
  assign busy            = (r_state == ST_GRANT) || (r_state == ST_GAP);
  assign timeout         = r_timeout;

endmodule

// File: tb/tb_hct138_rr_arbiter.sv
// Directed self-checking bench for hct138_rr_arbiter (default GAP_CYCLES=1, HOLD_MAX=16).
module tb_hct138_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       C, B, A, G, G_2A, G_2B, busy, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  hct138_rr_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .C       (C),
    .B       (B),
    .A       (A),
    .G       (G),
    .G_2A    (G_2A),
    .G_2B    (G_2B),
    .busy    (busy),
    .timeout (timeout)
  );

  wire [2:0] obs_sel = {C, B, A};
  wire       obs_en  = G & ~G_2A & ~G_2B;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = 8'h00;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Select must never move while the decoder is enabled.
  logic       prev_en  = 1'b0;
  logic [2:0] prev_sel = 3'd0;
  always @(negedge clk) begin
    if (prev_en && obs_en) begin
      n_cmp++;
      if (obs_sel !== prev_sel) begin
        n_bad++;
        $display("FAIL sel_stable: sel %0d while enabled, was %0d", obs_sel, prev_sel);
      end
    end
    prev_en  = obs_en;
    prev_sel = obs_sel;
  end

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({G, G_2A, G_2B, obs_sel, busy, timeout} !== 8'b011_000_0_0) begin
      n_bad++;
      $display("FAIL reset_outputs: got G/G2A/G2B=%b%b%b sel=%0d busy=%b to=%b, expected 011 0 0 0",
               G, G_2A, G_2B, obs_sel, busy, timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    req = 8'h08;
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd3 && busy === 1'b1)) begin
      n_bad++;
      $display("FAIL single_grant: got en=%b sel=%0d busy=%b, expected en=1 sel=3 busy=1",
               obs_en, obs_sel, busy);
    end
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd3)) begin
      n_bad++;
      $display("FAIL single_hold: got en=%b sel=%0d, expected en=1 sel=3", obs_en, obs_sel);
    end
    req = 8'h00;
    tick;
    n_cmp++;
    if (!(obs_en === 1'b0 && busy === 1'b1)) begin
      n_bad++;
      $display("FAIL single_gap: got en=%b busy=%b, expected en=0 busy=1", obs_en, busy);
    end
    tick;
    n_cmp++;
    if (!(obs_en === 1'b0 && busy === 1'b0)) begin
      n_bad++;
      $display("FAIL single_idle: got en=%b busy=%b, expected en=0 busy=0", obs_en, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp;
    do_reset;
    req = 8'hFF;
    tick;
    for (int g = 0; g < 9; g++) begin
      exp = g[2:0];
      n_cmp++;
      if (!(obs_en === 1'b1 && obs_sel === exp)) begin
        n_bad++;
        $display("FAIL rr_grant: step %0d got en=%b sel=%0d, expected en=1 sel=%0d",
                 g, obs_en, obs_sel, exp);
      end
      tick;
      tick;
      req[exp] = 1'b0;
      tick;
      req[exp] = 1'b1;
      n_cmp++;
      if (!(obs_en === 1'b0 && busy === 1'b1)) begin
        n_bad++;
        $display("FAIL rr_release: step %0d got en=%b busy=%b, expected en=0 busy=1",
                 g, obs_en, busy);
      end
      tick;
      n_cmp++;
      if (obs_en !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_gap_len: step %0d got en=%b, expected en=0", g, obs_en);
      end
      tick;
    end
    req = 8'h00;
    tick;
    tick;
    tick;
  endtask

  task automatic test_simultaneous;
    do_reset;
    req = 8'h10;
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd4)) begin
      n_bad++;
      $display("FAIL sim_setup: got en=%b sel=%0d, expected en=1 sel=4", obs_en, obs_sel);
    end
    req = 8'h00;
    tick;
    tick;
    req = 8'h24;
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd5)) begin
      n_bad++;
      $display("FAIL sim_first: got en=%b sel=%0d, expected en=1 sel=5", obs_en, obs_sel);
    end
    req = 8'h04;
    tick;
    tick;
    n_cmp++;
    if (obs_en !== 1'b0) begin
      n_bad++;
      $display("FAIL sim_gap: got en=%b, expected en=0", obs_en);
    end
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd2)) begin
      n_bad++;
      $display("FAIL sim_second: got en=%b sel=%0d, expected en=1 sel=2", obs_en, obs_sel);
    end
    req = 8'h00;
    tick;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    do_reset;
    req = 8'h40;
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd6)) begin
      n_bad++;
      $display("FAIL to_grant6: got en=%b sel=%0d, expected en=1 sel=6", obs_en, obs_sel);
    end
    req = 8'h42;
`ifdef ARB_TIMEOUT_EN
    for (int i = 2; i <= 16; i++) begin
      tick;
      n_cmp++;
      if (!(obs_en === 1'b1 && obs_sel === 3'd6 && timeout === 1'b0)) begin
        n_bad++;
        $display("FAIL to_hold: cycle %0d got en=%b sel=%0d to=%b, expected en=1 sel=6 to=0",
                 i, obs_en, obs_sel, timeout);
      end
    end
    tick;
    n_cmp++;
    if (!(obs_en === 1'b0 && timeout === 1'b1)) begin
      n_bad++;
      $display("FAIL to_force: got en=%b to=%b, expected en=0 to=1", obs_en, timeout);
    end
    tick;
    n_cmp++;
    if (!(obs_en === 1'b0 && timeout === 1'b0)) begin
      n_bad++;
      $display("FAIL to_pulse_end: got en=%b to=%b, expected en=0 to=0", obs_en, timeout);
    end
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd1)) begin
      n_bad++;
      $display("FAIL to_next: got en=%b sel=%0d, expected en=1 sel=1", obs_en, obs_sel);
    end
`else
    for (int i = 0; i < 110; i++) begin
      tick;
      n_cmp++;
      if (!(obs_en === 1'b1 && obs_sel === 3'd6 && timeout === 1'b0)) begin
        n_bad++;
        $display("FAIL hold_forever: cycle %0d got en=%b sel=%0d to=%b, expected 1 6 0",
                 i, obs_en, obs_sel, timeout);
      end
    end
`endif
    req = 8'h00;
    tick;
    tick;
    tick;
  endtask

  task automatic test_async_reset;
    do_reset;
    req = 8'h08;
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd3)) begin
      n_bad++;
      $display("FAIL ar_setup: got en=%b sel=%0d, expected en=1 sel=3", obs_en, obs_sel);
    end
    #3;
    rst = 1'b1;
    req = 8'h80;
    #1;
    n_cmp++;
    if ({G, G_2A, G_2B, obs_sel, busy, timeout} !== 8'b011_000_0_0) begin
      n_bad++;
      $display("FAIL ar_immediate: got G/G2A/G2B=%b%b%b sel=%0d busy=%b, expected 011 0 0",
               G, G_2A, G_2B, obs_sel, busy);
    end
    #1;
    rst = 1'b0;
    tick;
    n_cmp++;
    if (!(obs_en === 1'b1 && obs_sel === 3'd7)) begin
      n_bad++;
      $display("FAIL ar_regrant: got en=%b sel=%0d, expected en=1 sel=7", obs_en, obs_sel);
    end
    req = 8'h00;
    tick;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    test_reset;
    test_single;
    test_round_robin;
    test_simultaneous;
    test_timeout;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
